step_dir_generator: RTL

- Command-side transmitter for the stepper controller: turns a target-position command into the 2-bit step/direction stream that the stepper top entity consumes.
- Accepts a signed target and a step period over a valid/ready handshake.
- Emits timed step pulses with direction setup time, tracks the commanded position, and reports done/aborted.
- Sits between the host/sequencer logic and the stepper top, in the same system1000 clock domain.

---
 rtl/step_dir_pkg.sv | 37 +++
 rtl/step_timer.sv | 42 ++++
 rtl/step_dir_generator.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/step_dir_pkg.sv
// ---------------------------------------------------------------------------
// step_dir_pkg
//
// Shared definitions for the step/direction command transmitter:
//   - FSM state encoding (IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW)
//   - bit positions inside the 2-bit step_dir bus
//   - default width / timing constants
//   - small integer helper used to size the shared timer
// ---------------------------------------------------------------------------
package step_dir_pkg;

  // FSM state encoding, kept as plain 2-bit constants so the state register
  // stays a simple logic vector that legacy tools and netlists can follow.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DIR_SETUP = 2'd1;
  localparam logic [1:0] ST_STEP_HIGH = 2'd2;
  localparam logic [1:0] ST_STEP_LOW  = 2'd3;

  // Layout of the step_dir bus consumed by the stepper top.
  localparam int STEP_BIT = 0;
  localparam int DIR_BIT  = 1;

  // Default sizing and timing.
  localparam int DEF_POS_W            = 16;
  localparam int DEF_PERIOD_W         = 16;
  localparam int DEF_STEP_HIGH_CYCLES = 4;
  localparam int DEF_DIR_SETUP_CYCLES = 2;

  // The timer never gets narrower than 8 bits so the fixed setup and
  // high-time reloads always fit, even with a very narrow period field.
  localparam int MIN_TIMER_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/step_timer.sv
// ---------------------------------------------------------------------------
// step_timer
//
// Loadable down-counter shared by all timed FSM states. A load strobe
// copies load_value into the counter; otherwise the counter decrements
// until it reaches zero and then holds. zero is high while the count is 0,
// so a state that loads N-1 on entry lasts exactly N cycles.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous reset, active low
//   load       in   reload strobe
//   load_value in   W-bit value copied on load
//   zero       out  count has reached zero
// ---------------------------------------------------------------------------
module step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/step_dir_generator.sv
// ---------------------------------------------------------------------------
// step_dir_generator
//
// Command-side transmitter for the stepper controller. Accepts an absolute
// signed target and a step period over valid/ready, then emits step pulses
// on step_dir with a direction setup time ahead of the first pulse, keeps
// the commanded position, and reports done or aborted with one-cycle pulses.
//
// Ports:
//   system1000       in   clock
//   system1000_rstn  in   asynchronous reset, active low
//   cmd_valid        in   command offered
//   cmd_ready        out  high only while IDLE
//   cmd_target       in   POS_W signed absolute target position
//   cmd_period       in   PERIOD_W step period in cycles (rise to rise)
//   abort            in   stop-motion request
//   step_dir         out  bit1 = dir (1 = increasing), bit0 = step
//   position         out  POS_W signed count of issued steps
//   busy             out  motion in progress
//   done             out  one-cycle pulse: target reached
//   aborted          out  one-cycle pulse: motion ended by abort
// ---------------------------------------------------------------------------
module step_dir_generator
  import step_dir_pkg::*;
#(
  parameter int POS_W            = DEF_POS_W,
  parameter int PERIOD_W         = DEF_PERIOD_W,
  parameter int STEP_HIGH_CYCLES = DEF_STEP_HIGH_CYCLES,
  parameter int DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES
) (
  input  logic                system1000,
  input  logic                system1000_rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [POS_W-1:0]    cmd_target,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [1:0]          step_dir,
  output logic [POS_W-1:0]    position,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  localparam int TW = max_int(PERIOD_W, MIN_TIMER_W);

  // Shortest legal period: the full high time plus at least one low cycle.
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(STEP_HIGH_CYCLES + 1);

  // Timer reloads are "cycles - 1" because the state exits on the zero count.
  localparam logic [TW-1:0] SETUP_LOAD = TW'(DIR_SETUP_CYCLES - 1);
  localparam logic [TW-1:0] HIGH_LOAD  = TW'(STEP_HIGH_CYCLES - 1);

  logic [1:0]          state_q,  state_n;
  logic                step_q,   step_n;
  logic                dir_q,    dir_n;
  logic [POS_W-1:0]    position_q, pos_n;
  logic [POS_W-1:0]    target_q, target_n;
  logic [PERIOD_W-1:0] period_q, period_n;
  logic                busy_q,   busy_n;
  logic                done_q,   done_n;
  logic                aborted_q, aborted_n;
  // Remembers an abort seen during a pulse so the pulse can finish first.
  logic                abort_pend_q, pend_n;

  logic                tmr_load;
  logic [TW-1:0]       tmr_value;
  logic                tmr_zero;

  logic [PERIOD_W-1:0] eff_period;
  logic [TW-1:0]       low_load;
  logic                at_target;
  logic [POS_W-1:0]    pos_stepped;

  step_timer #(
    .W (TW)
  ) u_timer (
    .clk        (system1000),
    .rst_n      (system1000_rstn),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  assign eff_period  = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
  // Low time is period - high time; minus one more for the zero-exit count.
  assign low_load    = TW'(period_q) - TW'(STEP_HIGH_CYCLES + 1);
  assign at_target   = (position_q == target_q);
  // The position moves on the same edge the step line rises.
  assign pos_stepped = dir_q ? (position_q + POS_W'(1)) : (position_q - POS_W'(1));

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state_q;
    step_n    = step_q;
    dir_n     = dir_q;
    pos_n     = position_q;
    target_n  = target_q;
    period_n  = period_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    pend_n    = abort_pend_q;
    tmr_load  = 1'b0;
    tmr_value = '0;

    case (state_q)
      ST_IDLE: begin
        pend_n = 1'b0;
        if (cmd_valid) begin
          target_n = cmd_target;
          period_n = eff_period;
          if (cmd_target == position_q) begin
            // Already there: acknowledge without any motion.
            done_n = 1'b1;
          end else begin
            dir_n     = ($signed(cmd_target) > $signed(position_q));
            busy_n    = 1'b1;
            state_n   = ST_DIR_SETUP;
            tmr_load  = 1'b1;
            tmr_value = SETUP_LOAD;
          end
        end
      end

      ST_DIR_SETUP: begin
        if (abort) begin
          state_n   = ST_IDLE;
          busy_n    = 1'b0;
          done_n    = at_target;
          aborted_n = !at_target;
        end else if (tmr_zero) begin
          state_n   = ST_STEP_HIGH;
          step_n    = 1'b1;
          pos_n     = pos_stepped;
          tmr_load  = 1'b1;
          tmr_value = HIGH_LOAD;
        end
      end

      ST_STEP_HIGH: begin
        // An abort never truncates a pulse; it is held until the high time ends.
        if (abort) begin
          pend_n = 1'b1;
        end
        if (tmr_zero) begin
          step_n = 1'b0;
          pend_n = 1'b0;
          if (abort_pend_q || abort) begin
            state_n   = ST_IDLE;
            busy_n    = 1'b0;
            done_n    = at_target;
            aborted_n = !at_target;
          end else begin
            state_n   = ST_STEP_LOW;
            tmr_load  = 1'b1;
            tmr_value = low_load;
          end
        end
      end

      ST_STEP_LOW: begin
        // Abort wins over the next step, but a move that already reached its
        // target still reports done.
        if (abort) begin
          state_n   = ST_IDLE;
          busy_n    = 1'b0;
          done_n    = at_target;
          aborted_n = !at_target;
        end else if (tmr_zero) begin
          if (at_target) begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n   = ST_STEP_HIGH;
            step_n    = 1'b1;
            pos_n     = pos_stepped;
            tmr_load  = 1'b1;
            tmr_value = HIGH_LOAD;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        step_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // NOTE: the asynchronous reset clears every register, so a reset mid-pulse
  // drops step at once and discards the command in flight.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q      <= ST_IDLE;
      step_q       <= 1'b0;
      dir_q        <= 1'b0;
      position_q   <= '0;
      target_q     <= '0;
      period_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_n;
      step_q       <= step_n;
      dir_q        <= dir_n;
      position_q   <= pos_n;
      target_q     <= target_n;
      period_q     <= period_n;
      busy_q       <= busy_n;
      done_q       <= done_n;
      aborted_q    <= aborted_n;
      abort_pend_q <= pend_n;
    end
  end

  assign cmd_ready          = (state_q == ST_IDLE);
  assign step_dir[STEP_BIT] = step_q;
  assign step_dir[DIR_BIT]  = dir_q;
  assign position           = position_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign aborted            = aborted_q;

endmodule
